// File: rtl/mem_stage_if.sv
// mem_stage_if: EM/MW handshake, data-SRAM response, bypass and flush signals of the memory stage.
interface mem_stage_if #(
  parameter int EM_BUS_WID = 195,
  parameter int MW_BUS_WID = 191
);
  logic                  EM_valid;
  logic [EM_BUS_WID-1:0] EM_BUS;
  logic                  M_allowin;
  logic                  MW_valid;
  logic [MW_BUS_WID-1:0] MW_BUS;
  logic                  W_allowin;
  logic                  data_sram_data_ok;
  logic [31:0]           data_sram_rdata;
  logic [38:0]           Mfw_BUS;
  logic                  ex_en;
  modport master (
    output EM_valid, EM_BUS, W_allowin, data_sram_data_ok, data_sram_rdata, ex_en,
    input  M_allowin, MW_valid, MW_BUS, Mfw_BUS
  );
  modport slave (
    input  EM_valid, EM_BUS, W_allowin, data_sram_data_ok, data_sram_rdata, ex_en,
    output M_allowin, MW_valid, MW_BUS, Mfw_BUS
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage with load-response FSM, 1-entry response buffer and bypass bus.
// Defining MEM_UNALIGN_EX_EN turns misaligned half/word loads into address-alignment exceptions.
module mem_stage #(
  parameter int EM_BUS_WID = 195,
  parameter int MW_BUS_WID = 191
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);
`ifdef MEM_UNALIGN_EX_EN
  localparam bit UNALIGN_EX = 1'b1;
`else
  localparam bit UNALIGN_EX = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, CANCEL} state_t;
  state_t state, state_nx;
  logic                  m_valid, buf_valid;
  logic [31:0]           buf_data, rd, ld_data, final_result;
  logic [EM_BUS_WID-1:0] em;
  logic [2:0]            ld_type, in_type;
  logic [1:0]            va, in_va;
  logic [7:0]            b;
  logic [15:0]           h;
  logic ld_en, mis_m, mis_in, need_resp, in_need, ok_w, have_data, ld_pending;
  logic ready_go, leave, latch, gr_we_o;
  assign ld_en   = em[194];
  assign ld_type = em[193:191];
  assign va      = em[90:89];
  assign in_type = bus.EM_BUS[193:191];
  assign in_va   = bus.EM_BUS[90:89];
  assign mis_m  = UNALIGN_EX && ld_en && !em[88] &&
                  (((ld_type == 3'd1 || ld_type == 3'd5) && va[0]) || (ld_type == 3'd2 && va != 2'b00));
  assign mis_in = UNALIGN_EX && bus.EM_BUS[194] && !bus.EM_BUS[88] &&
                  (((in_type == 3'd1 || in_type == 3'd5) && in_va[0]) || (in_type == 3'd2 && in_va != 2'b00));
  // Only loads that reached the SRAM (no exception) ever get a response.
  assign need_resp  = ld_en && !em[88] && !mis_m;
  assign in_need    = bus.EM_BUS[194] && !bus.EM_BUS[88] && !mis_in;
  assign ok_w       = (state == WAIT) && bus.data_sram_data_ok;
  assign have_data  = buf_valid || ok_w;
  assign ld_pending = m_valid && need_resp && !have_data;
  assign ready_go   = !ld_pending;
  assign bus.M_allowin = (state != CANCEL) && (!m_valid || (ready_go && bus.W_allowin));
  assign bus.MW_valid  = m_valid && ready_go;
  assign leave = bus.MW_valid && bus.W_allowin;
  assign latch = bus.EM_valid && bus.M_allowin && !bus.ex_en;
  assign rd = buf_valid ? buf_data : bus.data_sram_rdata;
  assign b  = 8'(rd >> {va, 3'b000});
  assign h  = va[1] ? rd[31:16] : rd[15:0];
  always_comb begin
    ld_data = ld_type == 3'd0 ? {{24{b[7]}}, b} :
              ld_type == 3'd1 ? {{16{h[15]}}, h} :
              ld_type == 3'd4 ? {24'b0, b} :
              ld_type == 3'd5 ? {16'b0, h} : rd;
    final_result = ld_en ? ld_data : em[158:127];
  end
  assign gr_we_o = em[126] && !mis_m;
  assign bus.MW_BUS = MW_BUS_WID'({em[190:159], final_result, gr_we_o, em[125:89], em[88] | mis_m,
                                   mis_m ? 8'h09 : em[87:80], em[79] && !mis_m, em[78:0]});
  assign bus.Mfw_BUS = {gr_we_o && m_valid, ld_pending, em[125:121], final_result};
  // A flush in WAIT leaves one response in flight; CANCEL swallows it unless it arrives with the flush.
  always_comb begin
    state_nx = bus.ex_en ? ((state == IDLE || bus.data_sram_data_ok) ? IDLE : CANCEL) :
               latch ? (in_need ? WAIT : IDLE) :
               bus.data_sram_data_ok ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_valid   <= 1'b0;
      em        <= '0;
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else begin
      state <= state_nx;
      if (bus.ex_en) m_valid <= 1'b0;
      else if (bus.M_allowin) m_valid <= bus.EM_valid;
      if (latch) em <= bus.EM_BUS;
      if (bus.ex_en || leave) buf_valid <= 1'b0;
      else if (ok_w && !bus.W_allowin) begin
        buf_valid <= 1'b1;
        buf_data  <= bus.data_sram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage handshake, load extraction, stall, backpressure, flush and reset.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  mem_stage_if ifc ();
  mem_stage dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  wire [31:0] fr = ifc.MW_BUS[158:127];

  function automatic logic [194:0] mk(input logic ld, input logic [2:0] t, input logic [31:0] alu,
                                      input logic [4:0] dest, input logic [31:0] va);
    return {ld, t, 32'h1c00_0000, alu, 1'b1, dest, va, 1'b0, 8'h00, 1'b0, 14'h0, 1'b0, 32'h0, 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] va,
                         input logic [31:0] rdv, input logic [31:0] exp);
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, t, 32'hAAAA_AAAA, 5'd7, va); ifc.W_allowin = 1'b1;
    cyc(); ifc.EM_valid = 1'b0; ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = rdv;
    mid(); chk({tag, "_valid"}, ifc.MW_valid, 1); chk(tag, fr, exp);
    cyc(); ifc.data_sram_data_ok = 1'b0; ifc.data_sram_rdata = '0;
    mid(); chk({tag, "_drain"}, ifc.MW_valid, 0);
  endtask

  initial begin
    ifc.EM_valid = 1'b0; ifc.EM_BUS = '0; ifc.W_allowin = 1'b0;
    ifc.data_sram_data_ok = 1'b0; ifc.data_sram_rdata = '0; ifc.ex_en = 1'b0;
    // Reset must hold state even with live inputs.
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h5, 5'd3, 32'h10); ifc.data_sram_data_ok = 1'b1;
    mid(); chk("rst_mwvalid", ifc.MW_valid, 0); chk("rst_fw", ifc.Mfw_BUS, 0); chk("rst_allowin", ifc.M_allowin, 1);
    cyc();
    mid(); chk("rst_mwvalid2", ifc.MW_valid, 0); chk("rst_fw2", ifc.Mfw_BUS, 0);
    // Non-load ALU op
    cyc(); rst = 1'b0; ifc.data_sram_data_ok = 1'b0;
    ifc.EM_BUS = mk(1'b0, 3'd0, 32'h1234_5678, 5'd5, 32'h0); ifc.W_allowin = 1'b1;
    mid(); chk("alu_allowin", ifc.M_allowin, 1);
    cyc(); ifc.EM_valid = 1'b0;
    mid(); chk("alu_valid", ifc.MW_valid, 1); chk("alu_result", fr, 32'h1234_5678);
    chk("alu_fw", ifc.Mfw_BUS, {1'b1, 1'b0, 5'd5, 32'h1234_5678});
    cyc();
    mid(); chk("alu_drain", ifc.MW_valid, 0);
    // Load extraction
    do_load("lb",  3'd0, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    do_load("lh",  3'd1, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lhu", 3'd5, 32'h102, 32'h80FF_0000, 32'h0000_80FF);
    do_load("lb0", 3'd0, 32'h100, 32'h1234_567F, 32'h0000_007F);
    do_load("lw",  3'd2, 32'h100, 32'h89AB_CDEF, 32'h89AB_CDEF);
    do_load("lt3", 3'd3, 32'h101, 32'h89AB_CDEF, 32'h89AB_CDEF);
    // Stall: response three cycles late, next instruction waiting upstream
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd8, 32'h200);
    cyc(); ifc.EM_BUS = mk(1'b0, 3'd0, 32'h0BAD_F00D, 5'd9, 32'h0);
    for (int i = 0; i < 3; i++) begin
      mid(); chk("stall_valid", ifc.MW_valid, 0); chk("stall_allowin", ifc.M_allowin, 0);
      chk("stall_pending", ifc.Mfw_BUS[37], 1);
      cyc();
    end
    ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'hCAFE_F00D;
    mid(); chk("stall_ok_valid", ifc.MW_valid, 1); chk("stall_ok_allowin", ifc.M_allowin, 1);
    chk("stall_ok_result", fr, 32'hCAFE_F00D);
    cyc(); ifc.data_sram_data_ok = 1'b0; ifc.EM_valid = 1'b0;
    mid(); chk("stall_next_valid", ifc.MW_valid, 1); chk("stall_next_result", fr, 32'h0BAD_F00D);
    cyc();
    mid(); chk("stall_drain", ifc.MW_valid, 0);
    // Backpressure: response buffered while downstream is blocked
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd10, 32'h400);
    cyc(); ifc.EM_valid = 1'b0; ifc.W_allowin = 1'b0; ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'hDEAD_BEEF;
    mid(); chk("bp_allowin", ifc.M_allowin, 0); chk("bp_result", fr, 32'hDEAD_BEEF);
    cyc(); ifc.data_sram_data_ok = 1'b0; ifc.data_sram_rdata = 32'h0;
    mid(); chk("bp_buf_valid", ifc.MW_valid, 1); chk("bp_buf_result", fr, 32'hDEAD_BEEF);
    chk("bp_buf_pending", ifc.Mfw_BUS[37], 0);
    cyc(); ifc.W_allowin = 1'b1;
    mid(); chk("bp_rel_valid", ifc.MW_valid, 1); chk("bp_rel_result", fr, 32'hDEAD_BEEF);
    cyc();
    mid(); chk("bp_drain", ifc.MW_valid, 0);
    // Flush during WAIT, stale response discarded
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd11, 32'h300);
    cyc(); ifc.ex_en = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd12, 32'h304);
    mid(); chk("fl_allowin", ifc.M_allowin, 0);
    cyc(); ifc.ex_en = 1'b0;
    mid(); chk("fl_cancel_valid", ifc.MW_valid, 0); chk("fl_cancel_allowin", ifc.M_allowin, 0);
    cyc(); ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'h1111_1111;
    mid(); chk("fl_discard_valid", ifc.MW_valid, 0); chk("fl_discard_allowin", ifc.M_allowin, 0);
    cyc(); ifc.data_sram_data_ok = 1'b0; ifc.data_sram_rdata = 32'h0;
    mid(); chk("fl_idle_allowin", ifc.M_allowin, 1);
    cyc(); ifc.EM_valid = 1'b0;
    mid(); chk("fl_wait_valid", ifc.MW_valid, 0); chk("fl_wait_pending", ifc.Mfw_BUS[37], 1);
    cyc(); ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'h2222_2222;
    mid(); chk("fl_new_valid", ifc.MW_valid, 1); chk("fl_new_result", fr, 32'h2222_2222);
    chk("fl_new_dest", ifc.Mfw_BUS[36:32], 5'd12);
    cyc(); ifc.data_sram_data_ok = 1'b0;
    mid(); chk("fl_drain", ifc.MW_valid, 0);
    // data_ok together with flush: consumed, no CANCEL
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd13, 32'h500);
    cyc(); ifc.EM_valid = 1'b0; ifc.ex_en = 1'b1; ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'h3333_3333;
    cyc(); ifc.ex_en = 1'b0; ifc.data_sram_data_ok = 1'b0;
    mid(); chk("dx_dropped", ifc.MW_valid, 0); chk("dx_allowin", ifc.M_allowin, 1);
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd14, 32'h504);
    cyc(); ifc.EM_valid = 1'b0; ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'h5555_5555;
    mid(); chk("dx_next_valid", ifc.MW_valid, 1); chk("dx_next_result", fr, 32'h5555_5555);
    cyc(); ifc.data_sram_data_ok = 1'b0;
    mid(); chk("dx_drain", ifc.MW_valid, 0);
    // Reset mid-WAIT, stray response afterwards ignored
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd15, 32'h600);
    cyc(); ifc.EM_valid = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    mid(); chk("rw_valid", ifc.MW_valid, 0); chk("rw_allowin", ifc.M_allowin, 1); chk("rw_fw", ifc.Mfw_BUS, 0);
    cyc(); ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'h6666_6666;
    mid(); chk("rw_stray", ifc.MW_valid, 0);
    cyc(); ifc.data_sram_data_ok = 1'b0; ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd16, 32'h604);
    cyc(); ifc.EM_valid = 1'b0; ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'h7777_7777;
    mid(); chk("rw_next_valid", ifc.MW_valid, 1); chk("rw_next_result", fr, 32'h7777_7777);
    cyc(); ifc.data_sram_data_ok = 1'b0;
    mid(); chk("rw_drain", ifc.MW_valid, 0);
    // Reset mid-CANCEL
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd17, 32'h700);
    cyc(); ifc.EM_valid = 1'b0; ifc.ex_en = 1'b1;
    cyc(); ifc.ex_en = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    mid(); chk("rc_allowin", ifc.M_allowin, 1);
    // ld.w at a misaligned address
    cyc(); ifc.EM_valid = 1'b1; ifc.EM_BUS = mk(1'b1, 3'd2, 32'h0, 5'd18, 32'h1002);
    cyc(); ifc.EM_valid = 1'b0;
    mid();
`ifdef MEM_UNALIGN_EX_EN
    chk("ale_valid", ifc.MW_valid, 1); chk("ale_ex", ifc.MW_BUS[88], 1);
    chk("ale_ecode", ifc.MW_BUS[87:80], 8'h09); chk("ale_esub", ifc.MW_BUS[79], 0);
    chk("ale_gr_we", ifc.MW_BUS[126], 0); chk("ale_pending", ifc.Mfw_BUS[37], 0);
    cyc();
    mid(); chk("ale_drain", ifc.MW_valid, 0);
`else
    chk("mis_wait_valid", ifc.MW_valid, 0); chk("mis_ex", ifc.MW_BUS[88], 0);
    cyc(); ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = 32'h1234_4321;
    mid(); chk("mis_valid", ifc.MW_valid, 1); chk("mis_result", fr, 32'h1234_4321);
    cyc(); ifc.data_sram_data_ok = 1'b0;
    mid(); chk("mis_drain", ifc.MW_valid, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: EM_BUS_WID, default 195, width of the EM_BUS input.
REQ-002 Parameter: MW_BUS_WID, default 191, width of the MW_BUS output, which the downstream writeback stage consumes.
REQ-003 clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 M_allowin  out  1  the stage can accept a new instruction this cycle.
REQ-006 EM_valid  in  1  upstream holds a valid instruction.
REQ-007 EM_BUS  in  195  {ld_en, ld_type[2:0], pc[31:0], alu_result[31:0], gr_we, dest[4:0], vaddr[31:0], ex, ecode[7:0], esubcode, csr_addr[13:0], csr_we, csr_wmask[31:0], csr_wdata[31:0]}, listed MSB first.
REQ-008 W_allowin  in  1  the downstream stage can accept an instruction.
REQ-009 MW_valid  out  1  a valid instruction is presented downstream.
REQ-010 MW_BUS  out  191  same as EM_BUS without ld_en/ld_type; the result slot carries final_result.
REQ-011 data_sram_data_ok  in  1  a load response is valid this cycle.
REQ-012 data_sram_rdata  in  32  load response data.
REQ-013 Mfw_BUS  out  39  {gr_we&&M_valid, ld_pending, dest[4:0], final_result[31:0]}, the forwarding/bypass bus.
REQ-014 ex_en  in  1  pipeline flush, driven by exception or ertn commit.

Function
REQ-015 Handshake: M_allowin = !M_valid || (M_ready_go && W_allowin); MW_valid = M_valid && M_ready_go.
REQ-016 Latching: on EM_valid && M_allowin the stage latches EM_BUS and sets M_valid; on M_allowin && !EM_valid it clears M_valid.
REQ-017 FSM has 3 states: IDLE, WAIT, CANCEL.
REQ-018 IDLE->WAIT: an instruction with ld_en=1 and ex=0 is latched.
REQ-019 WAIT->IDLE: data_ok=1 arrives.
REQ-020 M_ready_go = 0 in WAIT, and 1 in IDLE unless a load is still pending.
REQ-021 Response buffer: when data_ok arrives and W_allowin=0, rdata is captured into a 1-entry buffer with a valid flag. The buffer clears when the instruction moves downstream.
REQ-022 Load extraction, selected by vaddr[1:0]:
- ld_type 0: signed byte.
- ld_type 1: signed half.
- ld_type 2: word.
- ld_type 4: unsigned byte.
- ld_type 5: unsigned half.
REQ-023 Other ld_type codes return the full word.
REQ-024 final_result = extracted load data when ld_en, else alu_result.
REQ-025 Flush: ex_en clears M_valid the same cycle-edge, with priority over latching.
REQ-026 ex_en while in WAIT: the FSM goes to CANCEL; CANCEL discards exactly one following data_ok, then returns to IDLE.
REQ-027 CANCEL with a new load latched: the new load cannot complete until after the discard, so stale data never reaches MW_BUS.
REQ-028 data_ok and ex_en in the same WAIT cycle: the response is consumed, the FSM returns to IDLE, and the instruction is dropped.
REQ-029 ld_pending = M_valid && ld_en && response not yet received.
REQ-030 M_allowin = 0 while in CANCEL.

Reset
REQ-031 While rst=1:
- M_valid=0, FSM=IDLE, buffer valid=0, latched bus=0.
- Hence MW_valid=0, Mfw_BUS=0, M_allowin=1.
REQ-032 rst asserted mid-WAIT or mid-CANCEL: all state is abandoned; any later stray data_ok in IDLE is ignored.

Configuration
REQ-033 Macro MEM_UNALIGN_EX_EN defined: a load (ld_en=1, ex=0) with a misaligned vaddr raises an address-alignment exception.
- Misaligned means a half with vaddr[0]=1, or a word with vaddr[1:0]!=0.
- On MW_BUS: ex=1, ecode=0x09, esubcode=0, gr_we=0.
- The FSM stays in IDLE.
REQ-034 MEM_UNALIGN_EX_EN undefined: no check is made; the low address bits are ignored for word loads.

Verification
REQ-035 Non-load: ALU op with alu_result=0x1234_5678, W_allowin=1 -> MW_valid next cycle, final_result=0x1234_5678.
REQ-036 Load byte: ld_type 0, vaddr=0x...03, rdata=0x80FF_0000 -> final_result=0xFFFF_FF80. Same with ld_type 4 -> 0x0000_0080.
REQ-037 Stall: load with data_ok 3 cycles late -> MW_valid=0 and M_allowin=0 until data_ok; MW_valid asserts in the data_ok cycle.
REQ-038 Backpressure: data_ok while W_allowin=0 for 2 cycles, rdata=0xDEAD_BEEF -> MW_BUS holds 0xDEAD_BEEF on release.
REQ-039 Flush: ex_en during WAIT, then a new lw; first data_ok=0x1111_1111 (discarded), second=0x2222_2222 -> only 0x2222_2222 is seen downstream.
REQ-040 MEM_UNALIGN_EX_EN: ld.w with vaddr=0x1002 -> ex=1, ecode=0x09, MW_valid without waiting for data_ok.
